// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared types and constants for the memory initiator and its users.
//   ADDR_W / DATA_W   : memory port geometry (32 words x 8 bits)
//   mem_init_state_t  : initiator FSM states
//   mem_req_t         : one command as issued by the control path
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_ACCESS,
        WR_ACCESS,
        VERIFY,
        RESP
    } mem_init_state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_initiator.sv
// ---------------------------------------------------------------------------
// mem_initiator
// Master side of the CPU's 32x8 memory port. Takes one read or write command
// at a time over a valid/ready handshake, drives address/writeData/memRead/
// memWrite to the memory, registers read data and returns a one-cycle
// response pulse.
//
// Optional build macro: MEM_INITIATOR_VERIFY_EN
//   Adds a read-back VERIFY cycle after every write and a sticky verify_err
//   output. Without it there is no VERIFY state and no verify_err port.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   req_valid/req_ready   command handshake
//   req_write/addr/wdata  command fields (held stable until accepted)
//   rsp_valid             one-cycle completion pulse for reads and writes
//   rsp_data              last read value, held until the next read completes
//   mem_address           memory address (stable between acceptances)
//   mem_writeData         memory write data (stable between acceptances)
//   mem_memRead           memory read enable
//   mem_memWrite          memory write enable
//   mem_rdata             combinational read data from memory
//   busy                  high whenever the FSM is not IDLE
//   verify_err            (VERIFY build only) sticky write-verify failure
//
// State table
//   IDLE      | ready for a command
//   RD_ACCESS | memRead held for WAIT_CYCLES+1 cycles, data sampled on last
//   WR_ACCESS | memWrite high for exactly one cycle
//   VERIFY    | read-back of the written word, compared with writeData
//   RESP      | rsp_valid pulse, then back to IDLE
// ---------------------------------------------------------------------------
module mem_initiator #(
    parameter int ADDR_W      = mem_pkg::ADDR_W,
    parameter int DATA_W      = mem_pkg::DATA_W,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    output logic              mem_memRead,
    output logic              mem_memWrite,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef MEM_INITIATOR_VERIFY_EN
    ,
    output logic              verify_err
`endif
);

    import mem_pkg::*;

    localparam logic [2:0] WAIT_LD = 3'(WAIT_CYCLES);

    mem_init_state_t state, state_nxt;
    logic [2:0]      wait_cnt;
    logic            accept;
    logic            rd_last;

    assign accept  = req_valid && (state == IDLE);
    // Down-counter reaches terminal count on the last memRead cycle.
    assign rd_last = (state == RD_ACCESS) && (wait_cnt == 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Memory strobes are decoded from the state register only, so an
    // asynchronous reset removes memWrite immediately and no partial write
    // reaches the memory.
    always_comb begin
        state_nxt    = state;
        req_ready    = 1'b0;
        busy         = 1'b1;
        rsp_valid    = 1'b0;
        mem_memRead  = 1'b0;
        mem_memWrite = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    state_nxt = req_write ? WR_ACCESS : RD_ACCESS;
                end
            end
            RD_ACCESS: begin
                mem_memRead = 1'b1;
                if (wait_cnt == 3'd0) begin
                    state_nxt = RESP;
                end
            end
            WR_ACCESS: begin
                mem_memWrite = 1'b1;
`ifdef MEM_INITIATOR_VERIFY_EN
                state_nxt    = VERIFY;
`else
                state_nxt    = RESP;
`endif
            end
`ifdef MEM_INITIATOR_VERIFY_EN
            VERIFY: begin
                mem_memRead = 1'b1;
                state_nxt   = RESP;
            end
`endif
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_address   <= '0;
            mem_writeData <= '0;
            wait_cnt      <= 3'd0;
            rsp_data      <= '0;
        end else begin
            if (accept) begin
                mem_address   <= req_addr;
                mem_writeData <= req_wdata;
                wait_cnt      <= WAIT_LD;
            end else if ((state == RD_ACCESS) && (wait_cnt != 3'd0)) begin
                wait_cnt <= wait_cnt - 3'd1;
            end
            if (rd_last) begin
                rsp_data <= mem_rdata;
            end
        end
    end

`ifdef MEM_INITIATOR_VERIFY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            verify_err <= 1'b0;
        end else if ((state == VERIFY) && (mem_rdata != mem_writeData)) begin
            verify_err <= 1'b1;
        end
    end
`endif

endmodule
